// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel DDR2 client arbiter with grant locking and read-tag routing
module mem_arbiter #(
  parameter int NCH       = 6,
  parameter int ADDR_W    = 31,
  parameter int DATA_W    = 128,
  parameter int MASK_W    = 16,
  parameter int TAG_DEPTH = 16,
  parameter int RR_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_af_wr_en,
  input  logic [3*NCH-1:0]      ch_af_cmd_din,
  input  logic [ADDR_W*NCH-1:0] ch_addr_din,
  input  logic [NCH-1:0]        ch_wdf_wr_en,
  input  logic [DATA_W*NCH-1:0] ch_wdf_din,
  input  logic [MASK_W*NCH-1:0] ch_wdf_mask_din,
  input  logic [NCH-1:0]        ch_rdf_rd_en,
  output logic [NCH-1:0]        ch_af_full,
  output logic [NCH-1:0]        ch_wdf_full,
  output logic [NCH-1:0]        ch_rdf_valid,
  input  logic                  af_full,
  input  logic                  wdf_full,
  input  logic                  rdf_valid,
  output logic                  af_wr_en,
  output logic [2:0]            af_cmd_din,
  output logic [ADDR_W-1:0]     addr_din,
  output logic                  wdf_wr_en,
  output logic [DATA_W-1:0]     wdf_din,
  output logic [MASK_W-1:0]     wdf_mask_din,
  output logic                  rdf_rd_en,
  output logic                  err_orphan
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] g, last_g, win, head;
  logic          win_found;
  logic          txn_rd, cmd_done;
  logic [1:0]    beat_cnt;
  logic          cmd_acc, beat_acc, done, block;
  logic          tag_push, tag_pop, tag_full, tag_empty, rd_acc, rbeat;
  logic [TW-1:0] wr_ptr, rd_ptr;
  logic [TW:0]   tag_cnt;
  logic [GW-1:0] tag_mem [TAG_DEPTH];

  // Winner selection: lowest index, or first requester after the last grant.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < NCH; k++) begin
        if (!win_found && ch_af_wr_en[(int'(last_g) + 1 + k) % NCH]) begin
          win       = GW'((int'(last_g) + 1 + k) % NCH);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (ch_af_wr_en[k]) begin
          win       = GW'(k);
          win_found = 1'b1;
        end
      end
    end
  end

  assign tag_full  = (tag_cnt == (TW+1)'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign head      = tag_mem[rd_ptr];

  assign af_cmd_din   = ch_af_cmd_din[int'(g)*3 +: 3];
  assign addr_din     = ch_addr_din[int'(g)*ADDR_W +: ADDR_W];
  assign wdf_din      = ch_wdf_din[int'(g)*DATA_W +: DATA_W];
  assign wdf_mask_din = ch_wdf_mask_din[int'(g)*MASK_W +: MASK_W];

  always_comb begin
    state_nx     = state;
    ch_af_full   = '1;
    ch_wdf_full  = '1;
    ch_rdf_valid = '0;
    rdf_rd_en    = 1'b0;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    done         = 1'b0;

    // Return path follows the tag head regardless of who owns the command side.
    if (!tag_empty) begin
      ch_rdf_valid[head] = rdf_valid;
      rdf_rd_en          = ch_rdf_rd_en[head];
    end
    rd_acc  = rdf_rd_en & rdf_valid;
    tag_pop = rd_acc & rbeat;

    // A read may slip into a full tag queue only when a slot frees this cycle.
    block = cmd_done | (txn_rd & tag_full & ~tag_pop);

    if (state == S_OWN) begin
      af_wr_en       = ch_af_wr_en[g] & ~block;
      wdf_wr_en      = ~txn_rd & ch_wdf_wr_en[g] & (beat_cnt != 2'd2);
      ch_af_full[g]  = af_full | block;
      ch_wdf_full[g] = txn_rd | wdf_full | (beat_cnt == 2'd2);
    end
    cmd_acc  = af_wr_en & ~af_full;
    beat_acc = wdf_wr_en & ~wdf_full;
    tag_push = cmd_acc & txn_rd;

    case (state)
      S_IDLE: if (win_found) state_nx = S_OWN;
      S_OWN: begin
        if (txn_rd) done = cmd_acc;
        else        done = (cmd_done | cmd_acc) & ((beat_cnt + {1'b0, beat_acc}) == 2'd2);
        if (done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      g          <= '0;
      last_g     <= GW'(NCH - 1);
      txn_rd     <= 1'b0;
      cmd_done   <= 1'b0;
      beat_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      rbeat      <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && win_found) begin
        g        <= win;
        txn_rd   <= (ch_af_cmd_din[int'(win)*3 +: 3] == 3'b001);
        cmd_done <= 1'b0;
        beat_cnt <= '0;
      end else if (state == S_OWN) begin
        if (done) begin
          last_g   <= g;
          cmd_done <= 1'b0;
          beat_cnt <= '0;
        end else begin
          if (cmd_acc)  cmd_done <= 1'b1;
          if (beat_acc) beat_cnt <= beat_cnt + 2'd1;
        end
      end
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (rd_acc) rbeat <= ~rbeat;
      if (rdf_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr] <= g;
  end
endmodule
